// File: rtl/unidad_control_pipeline_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state codes,
// default drain length and the hazard-detection result bundle.
package unidad_control_pipeline_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_STEP_WAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN     = 3'd3;
    localparam logic [2:0] ST_HALTED    = 3'd4;

    localparam int DEF_DRAIN = 3;

    typedef struct packed {
        logic taken;
        logic loaduse;
    } hazard_t;

endpackage

// File: rtl/unidad_control_pipeline_riesgos.sv
// Combinational hazard detection: load-use dependency between EX and ID,
// and taken-branch resolution for the branch sitting in MEM.
module unidad_control_pipeline_riesgos
    import unidad_control_pipeline_pkg::*;
#(
    parameter int REGS = 5
) (
    input  logic [REGS-1:0] rs,
    input  logic [REGS-1:0] rt,
    input  logic            ex_mem_read,
    input  logic [REGS-1:0] ex_rd,
    input  logic            mem_branch,
    input  logic            mem_nbranch,
    input  logic            mem_cero,
    output hazard_t         haz
);

    always_comb begin
        haz.taken   = (mem_branch & mem_cero) | (mem_nbranch & ~mem_cero);
        // Register 0 is hardwired, so a load into it never creates a dependency.
        haz.loaduse = ex_mem_read & (ex_rd != '0) & ((ex_rd == rs) | (ex_rd == rt));
    end

endmodule

// File: rtl/unidad_control_pipeline.sv
// Pipeline sequencer: run/step FSM, HALT drain, stall/flush decode for the
// five stage registers and a saturating count of advance cycles.
module unidad_control_pipeline
    import unidad_control_pipeline_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int REGS  = 5,
    parameter int DRAIN = DEF_DRAIN
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Start,
    input  logic             i_StepMode,
    input  logic             i_Step,
    input  logic [REGS-1:0]  i_IF_ID_Rs,
    input  logic [REGS-1:0]  i_IF_ID_Rt,
    input  logic             i_ID_EX_MemRead,
    input  logic [REGS-1:0]  i_ID_EX_RegistroDestino,
    input  logic             i_EX_MEM_Branch,
    input  logic             i_EX_MEM_NBranch,
    input  logic             i_EX_MEM_Cero,
    input  logic             i_HaltID,
    output logic             o_PC_Enable,
    output logic             o_PCSrc,
    output logic             o_IF_ID_Enable,
    output logic             o_IF_ID_Flush,
    output logic             o_ID_EX_Enable,
    output logic             o_ID_EX_Flush,
    output logic             o_EX_MEM_Enable,
    output logic             o_EX_MEM_Flush,
    output logic             o_MEM_WB_Enable,
    output logic             o_Running,
    output logic             o_Halted,
    output logic [NBITS-1:0] o_CycleCount
);

    localparam int DCNT_W = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

    logic [2:0]        state, state_nxt;
    logic              step_r, step_nxt;
    logic [DCNT_W-1:0] dcnt, dcnt_nxt;
    logic [NBITS-1:0]  cycle_count;
    hazard_t           haz;
    logic              adv, in_exec, drain_abort;

    function automatic logic [NBITS-1:0] sat_inc(input logic [NBITS-1:0] v);
        return (&v) ? v : v + NBITS'(1);
    endfunction

    unidad_control_pipeline_riesgos #(.REGS(REGS)) u_riesgos (
        .rs          (i_IF_ID_Rs),
        .rt          (i_IF_ID_Rt),
        .ex_mem_read (i_ID_EX_MemRead),
        .ex_rd       (i_ID_EX_RegistroDestino),
        .mem_branch  (i_EX_MEM_Branch),
        .mem_nbranch (i_EX_MEM_NBranch),
        .mem_cero    (i_EX_MEM_Cero),
        .haz         (haz)
    );

    assign in_exec = (state == ST_RUN) | (state == ST_STEP_WAIT);
    assign adv     = (state == ST_RUN)
                   | ((state == ST_STEP_WAIT) & i_Step)
                   | ((state == ST_DRAIN) & (~step_r | i_Step));
    // Only the branch directly older than HALT can still be in MEM on the first drain cycle.
    assign drain_abort = (state == ST_DRAIN) & haz.taken & (dcnt == DCNT_W'(DRAIN));

    always_comb begin
        o_PC_Enable     = 1'b0;
        o_PCSrc         = 1'b0;
        o_IF_ID_Enable  = 1'b0;
        o_IF_ID_Flush   = 1'b0;
        o_ID_EX_Enable  = 1'b0;
        o_ID_EX_Flush   = 1'b0;
        o_EX_MEM_Enable = 1'b0;
        o_EX_MEM_Flush  = 1'b0;
        o_MEM_WB_Enable = 1'b0;
        state_nxt       = state;
        step_nxt        = step_r;
        dcnt_nxt        = dcnt;

        if ((state == ST_IDLE) && i_Start) begin
            step_nxt  = i_StepMode;
            state_nxt = i_StepMode ? ST_STEP_WAIT : ST_RUN;
        end

        if (adv) begin
            o_PC_Enable     = 1'b1;
            o_IF_ID_Enable  = 1'b1;
            o_ID_EX_Enable  = 1'b1;
            o_EX_MEM_Enable = 1'b1;
            o_MEM_WB_Enable = 1'b1;
            if (haz.taken && (in_exec || drain_abort)) begin
                o_PCSrc        = 1'b1;
                o_IF_ID_Flush  = 1'b1;
                o_ID_EX_Flush  = 1'b1;
                o_EX_MEM_Flush = 1'b1;
                if (drain_abort)
                    state_nxt = step_r ? ST_STEP_WAIT : ST_RUN;
            end else if (state == ST_DRAIN) begin
                o_PC_Enable   = 1'b0;
                o_IF_ID_Flush = 1'b1;
                if (haz.loaduse) begin
                    o_IF_ID_Enable = 1'b0;
                    o_ID_EX_Flush  = 1'b1;
                end else begin
                    dcnt_nxt = dcnt - DCNT_W'(1);
                    if (dcnt == DCNT_W'(1))
                        state_nxt = ST_HALTED;
                end
            end else if (haz.loaduse) begin
                o_PC_Enable    = 1'b0;
                o_IF_ID_Enable = 1'b0;
                o_ID_EX_Flush  = 1'b1;
            end else if (i_HaltID) begin
                o_PC_Enable   = 1'b0;
                o_IF_ID_Flush = 1'b1;
                state_nxt     = ST_DRAIN;
                dcnt_nxt      = DCNT_W'(DRAIN);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            step_r      <= 1'b0;
            dcnt        <= '0;
            cycle_count <= '0;
        end else begin
            state  <= state_nxt;
            step_r <= step_nxt;
            dcnt   <= dcnt_nxt;
            if (adv)
                cycle_count <= sat_inc(cycle_count);
        end
    end

    assign o_Running    = in_exec | (state == ST_DRAIN);
    assign o_Halted     = (state == ST_HALTED);
    assign o_CycleCount = cycle_count;

endmodule
